// File: rtl/fnd_scan_capture_if.sv
// Display scan bus between a 7-segment driver (master) and the capture block (slave).
// The scan lines flow master->slave; the decoded word flows back slave->master.
interface fnd_scan_capture_if #(
  parameter int DIGITS = 8
);
  logic [7:0]          digit;
  logic [7:0]          fnd;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   bad;
  logic                value_valid;
  logic                value_changed;
  logic                scan_err;

  modport master (
    output digit, fnd,
    input  value, dp, bad, value_valid, value_changed, scan_err
  );

  modport slave (
    input  digit, fnd,
    output value, dp, bad, value_valid, value_changed, scan_err
  );
endinterface

// File: rtl/fnd_scan_capture.sv
// Samples a multiplexed 7-segment scan, decodes each glyph back to a hex nibble and
// publishes the whole word once two consecutive complete frames agree.
module fnd_scan_capture #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fnd_scan_capture_if.slave    bus
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;

  typedef enum logic [1:0] {WAIT_SEL, DWELL, SAMPLED} state_t;

  // Active-low segments {dp,g..a}; dp is ignored. Result is {bad, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          d_q, f_q, pd_q, pf_q;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] fnib_q, fnib_d, pnib_q, pnib_d, value_q, value_d;
  logic [DIGITS-1:0]   fdp_q, fdp_d, pdp_q, pdp_d, odp_q, odp_d;
  logic [DIGITS-1:0]   fbad_q, fbad_d, pbad_q, pbad_d, obad_q, obad_d;
  logic                prv_ok_q, prv_ok_d, pub_q, pub_d, first_q, first_d;
  logic                valid_q, valid_d, changed_q, changed_d, err_q, err_d;

  logic [3:0] low_cnt;
  logic       low_in_range, legal, multi, same, sample, complete, frame_eq;
  logic [2:0] sel_idx;
  logic [4:0] dec;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    low_cnt      = '0;
    low_in_range = 1'b0;
    sel_idx      = '0;
    for (int i = 0; i < 8; i++) low_cnt = low_cnt + 4'(!d_q[i]);
    for (int i = 0; i < DIGITS; i++) begin
      if (!d_q[i]) begin
        low_in_range = 1'b1;
        sel_idx      = 3'(i);
      end
    end
    legal = low_in_range && (low_cnt == 4'd1);
    multi = (low_cnt >= 4'd2);
    same  = (d_q == pd_q) && (f_q == pf_q);
    dec   = decode(f_q[6:0]);

    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    case (state_q)
      WAIT_SEL: begin
        if (legal) begin
          state_d = DWELL;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      DWELL: begin
        if (!legal) begin
          state_d = WAIT_SEL;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d   = CW'(1);
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          sample  = 1'b1;
          state_d = SAMPLED;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      SAMPLED: begin
        if (!legal) begin
          state_d = WAIT_SEL;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = DWELL;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        state_d = WAIT_SEL;
        cnt_d   = '0;
      end
    endcase

    // A completed frame is compared against the previous one before it replaces it.
    complete = &mask_q;
    frame_eq = prv_ok_q && ({fnib_q, fdp_q, fbad_q} == {pnib_q, pdp_q, pbad_q});

    mask_d = complete ? '0 : mask_q;
    fnib_d = fnib_q;
    fdp_d  = fdp_q;
    fbad_d = fbad_q;
    if (sample) begin
      mask_d[sel_idx]           = 1'b1;
      fnib_d[4*sel_idx +: 4]    = dec[3:0];
      fdp_d[sel_idx]            = ~f_q[7];
      fbad_d[sel_idx]           = dec[4];
    end

    pnib_d   = complete ? fnib_q : pnib_q;
    pdp_d    = complete ? fdp_q  : pdp_q;
    pbad_d   = complete ? fbad_q : pbad_q;
    prv_ok_d = prv_ok_q | complete;
    pub_d    = complete && frame_eq;

    valid_d   = pub_q;
    changed_d = pub_q && (first_q || ({pnib_q, pdp_q, pbad_q} != {value_q, odp_q, obad_q}));
    value_d   = pub_q ? pnib_q : value_q;
    odp_d     = pub_q ? pdp_q  : odp_q;
    obad_d    = pub_q ? pbad_q : obad_q;
    first_d   = first_q && !pub_q;
    err_d     = err_q | multi;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: frame buffers are cleared too, so a stale frame can never match after reset.
      state_q   <= WAIT_SEL;
      cnt_q     <= '0;
      d_q       <= 8'hFF;
      f_q       <= 8'hFF;
      pd_q      <= 8'hFF;
      pf_q      <= 8'hFF;
      mask_q    <= '0;
      fnib_q    <= '0;
      fdp_q     <= '0;
      fbad_q    <= '0;
      pnib_q    <= '0;
      pdp_q     <= '0;
      pbad_q    <= '0;
      prv_ok_q  <= 1'b0;
      pub_q     <= 1'b0;
      first_q   <= 1'b1;
      value_q   <= '0;
      odp_q     <= '0;
      obad_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_q       <= bus.digit;
      f_q       <= bus.fnd;
      pd_q      <= d_q;
      pf_q      <= f_q;
      mask_q    <= mask_d;
      fnib_q    <= fnib_d;
      fdp_q     <= fdp_d;
      fbad_q    <= fbad_d;
      pnib_q    <= pnib_d;
      pdp_q     <= pdp_d;
      pbad_q    <= pbad_d;
      prv_ok_q  <= prv_ok_d;
      pub_q     <= pub_d;
      first_q   <= first_d;
      value_q   <= value_d;
      odp_q     <= odp_d;
      obad_q    <= obad_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  assign bus.value         = value_q;
  assign bus.dp            = odp_q;
  assign bus.bad           = obad_q;
  assign bus.value_valid   = valid_q;
  assign bus.value_changed = changed_q;
  assign bus.scan_err      = err_q;

endmodule

// File: tb/tb_fnd_scan_capture.sv
// Directed bench for fnd_scan_capture: drives display scans, predicts each publish
// into a queue, and a negedge monitor pops and compares whenever value_valid pulses.
module tb_fnd_scan_capture;

  localparam int DWELL = 6;
  localparam int GAP   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fnd_scan_capture_if #(.DIGITS(8)) bus ();

  fnd_scan_capture #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  bad;
    logic        changed;
  } pub_t;

  pub_t exp_q[$];
  pub_t last_pub;
  pub_t mon_e;
  bit   first_pub;
  int   n_assert  = 0;
  int   n_fail    = 0;
  int   pulse_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction

  function automatic logic [63:0] frame_of(input logic [31:0] nibs);
    logic [63:0] s;
    for (int i = 0; i < 8; i++) s[8*i +: 8] = glyph(nibs[4*i +: 4]);
    return s;
  endfunction

  task automatic push_expect(input logic [31:0] v, input logic [7:0] dpv, input logic [7:0] badv);
    pub_t e;
    e.value   = v;
    e.dp      = dpv;
    e.bad     = badv;
    e.changed = first_pub || ({v, dpv, badv} != {last_pub.value, last_pub.dp, last_pub.bad});
    last_pub  = e;
    first_pub = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] d, input logic [7:0] f, input int n);
    bus.digit = d;
    bus.fnd   = f;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_value"},   bus.value, 32'h0);
    check({tag, "_dp"},      32'(bus.dp), 32'h0);
    check({tag, "_bad"},     32'(bus.bad), 32'h0);
    check({tag, "_valid"},   32'(bus.value_valid), 32'h0);
    check({tag, "_changed"}, 32'(bus.value_changed), 32'h0);
    check({tag, "_scanerr"}, 32'(bus.scan_err), 32'h0);
  endtask

  task automatic apply_reset(input string tag, input int n);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    reset = 1'b0;
    repeat (n) begin
      bus.digit = 8'($urandom);
      bus.fnd   = 8'($urandom);
      @(negedge clk);
    end
    check_zero(tag);
    reset     = 1'b1;
    first_pub = 1'b1;
    last_pub  = '0;
  endtask

  // Drives digits 0..n_digits-1; digit 3 may get a custom dwell, and a double-select
  // glitch may be inserted right after digit 3.
  task automatic scan_frame(input logic [63:0] segs, input int n_digits,
                            input int d3_cycles, input bit inject_err);
    logic [7:0] sel;
    for (int i = 0; i < n_digits; i++) begin
      sel    = 8'hFF;
      sel[i] = 1'b0;
      drive(sel, segs[8*i +: 8], (i == 3) ? d3_cycles : DWELL);
      if (inject_err && i == 3) begin
        drive(8'hFC, 8'h00, 5);
        check("scan_err_set", 32'(bus.scan_err), 32'h1);
      end
    end
    if (n_digits == 8) drive(8'hFF, 8'hFF, GAP);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("changed_implies_valid",
            32'(bus.value_changed === 1'b1 && bus.value_valid !== 1'b1), 32'h0);
      if (bus.value_valid === 1'b1) begin
        pulse_cnt++;
        check("publish_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("pub_value",   bus.value, mon_e.value);
          check("pub_dp",      32'(bus.dp), 32'(mon_e.dp));
          check("pub_bad",     32'(bus.bad), 32'(mon_e.bad));
          check("pub_changed", 32'(bus.value_changed), 32'(mon_e.changed));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] seg_a, seg_t, seg_g;
    int          p0;
    seg_a     = frame_of(32'h87654321);
    seg_t     = frame_of(32'h87A54321);
    seg_g     = frame_of(32'h87654300);
    seg_g[7:0]  = 8'h40;
    seg_g[15:8] = 8'hFF;
    first_pub = 1'b1;
    last_pub  = '0;
    bus.digit = 8'hFF;
    bus.fnd   = 8'hFF;
    @(negedge clk);

    // Reset with toggling inputs, then one frame is not enough to publish.
    apply_reset("reset_hold", 3);
    scan_frame(seg_a, 8, DWELL, 1'b0);
    check("frame1_no_pulse", 32'(pulse_cnt), 32'h0);
    check_zero("after_frame1");

    // Steady scan: frame 2 publishes with change, frame 3 repeats without.
    push_expect(32'h87654321, 8'h00, 8'h00);
    scan_frame(seg_a, 8, DWELL, 1'b0);
    wait_drain("frame2");
    push_expect(32'h87654321, 8'h00, 8'h00);
    scan_frame(seg_a, 8, DWELL, 1'b0);
    wait_drain("frame3");
    check("steady_value_held", bus.value, 32'h87654321);

    // Dwell filter: a 3-cycle digit is never sampled, a 4-cycle one is.
    apply_reset("dwell_reset", 2);
    scan_frame(seg_a, 8, DWELL, 1'b0);
    p0 = pulse_cnt;
    scan_frame(seg_a, 8, 3, 1'b0);
    scan_frame(seg_a, 8, 3, 1'b0);
    check("short_dwell_no_publish", 32'(pulse_cnt), 32'(p0));
    check("short_dwell_value", bus.value, 32'h0);
    push_expect(32'h87654321, 8'h00, 8'h00);
    scan_frame(seg_a, 8, 4, 1'b0);
    wait_drain("dwell4");

    // Tear rejection: one differing frame is suppressed, its repeat publishes.
    apply_reset("tear_reset", 2);
    scan_frame(seg_a, 8, DWELL, 1'b0);
    push_expect(32'h87654321, 8'h00, 8'h00);
    scan_frame(seg_a, 8, DWELL, 1'b0);
    wait_drain("tear_f2");
    p0 = pulse_cnt;
    scan_frame(seg_t, 8, DWELL, 1'b0);
    check("tear_no_publish", 32'(pulse_cnt), 32'(p0));
    check("tear_value_held", bus.value, 32'h87654321);
    push_expect(32'h87A54321, 8'h00, 8'h00);
    scan_frame(seg_t, 8, DWELL, 1'b0);
    wait_drain("tear_f4");

    // Decimal point, non-glyph pattern and a double select mid-frame.
    apply_reset("glyph_reset", 2);
    scan_frame(seg_g, 8, DWELL, 1'b0);
    push_expect(32'h87654300, 8'h01, 8'h02);
    scan_frame(seg_g, 8, DWELL, 1'b1);
    wait_drain("glyph_f2");
    check("scan_err_sticky", 32'(bus.scan_err), 32'h1);

    // Mid-frame reset drops the partial frame; two fresh frames needed again.
    p0 = pulse_cnt;
    scan_frame(seg_a, 8, DWELL, 1'b0);
    check("changed_frame_no_publish", 32'(pulse_cnt), 32'(p0));
    scan_frame(seg_a, 4, DWELL, 1'b0);
    apply_reset("midframe_reset", 2);
    scan_frame(seg_a, 8, DWELL, 1'b0);
    check("post_reset_frame1_no_pulse", 32'(pulse_cnt), 32'(p0));
    check("post_reset_frame1_value", bus.value, 32'h0);
    push_expect(32'h87654321, 8'h00, 8'h00);
    scan_frame(seg_a, 8, DWELL, 1'b0);
    wait_drain("post_reset_f2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
